// File: rtl/interp_line_feeder_pkg.sv
// Shared types and constants for the interpolator line feeder.
// Optional column ordering is enabled by defining FEEDER_COLUMN_MODE_EN.
package interp_pkg;

   localparam int PIX_W      = 8;
   localparam int BLK_DIM    = 16;
   localparam int PAD_LEFT   = 7;
   localparam int PAD_RIGHT  = 6;
   localparam int LINE_BEATS = PAD_LEFT + BLK_DIM + PAD_RIGHT;
   localparam int TAP_FIRST  = 13;

   localparam int IDX_W  = $clog2(BLK_DIM);
   localparam int ADDR_W = 2 * IDX_W;
   localparam int BEAT_W = $clog2(LINE_BEATS);

   typedef logic [PIX_W-1:0]  pixel_t;
   typedef logic [IDX_W-1:0]  idx_t;
   typedef logic [BEAT_W-1:0] beat_idx_t;

   localparam beat_idx_t COL_FIRST_BEAT = beat_idx_t'(PAD_LEFT);
   localparam beat_idx_t COL_LAST_BEAT  = beat_idx_t'(PAD_LEFT + BLK_DIM - 1);
   localparam beat_idx_t TAP_BEAT       = beat_idx_t'(TAP_FIRST);
   localparam beat_idx_t LAST_BEAT      = beat_idx_t'(LINE_BEATS - 1);
   localparam idx_t      LAST_LINE      = idx_t'(BLK_DIM - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} feeder_state_e;

   typedef struct packed {
      logic last;
      logic tap_valid;
      idx_t tap_idx;
   } feeder_tags_t;

   typedef struct packed {
      pixel_t       data;
      idx_t         line;
      beat_idx_t    beat;
      feeder_tags_t tags;
   } feeder_beat_t;

   // Edge padding: the first and last pixel are replicated into the pad beats.
   function automatic idx_t pad_col(beat_idx_t beat);
      if (beat < COL_FIRST_BEAT) return '0;
      if (beat > COL_LAST_BEAT)  return idx_t'(BLK_DIM - 1);
      return idx_t'(beat - COL_FIRST_BEAT);
   endfunction

   function automatic feeder_tags_t make_tags(idx_t line, beat_idx_t beat);
      feeder_tags_t t;
      t.tap_valid = (beat >= TAP_BEAT);
      t.tap_idx   = t.tap_valid ? idx_t'(beat - TAP_BEAT) : '0;
      t.last      = (line == LAST_LINE) && (beat == LAST_BEAT);
      return t;
   endfunction

endpackage

// File: rtl/interp_line_feeder_if.sv
// Output beat stream from the line feeder to the interpolator shift register.
interface interp_line_feeder_if;
   import interp_pkg::*;

   logic      out_valid;
   logic      out_ready;
   pixel_t    out_data;
   idx_t      out_line;
   beat_idx_t out_beat;
   logic      out_last;
   logic      out_tap_valid;
   idx_t      out_tap_idx;

   modport master (
      output out_valid, out_data, out_line, out_beat, out_last, out_tap_valid, out_tap_idx,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_line, out_beat, out_last, out_tap_valid, out_tap_idx,
      output out_ready
   );
endinterface

// File: rtl/interp_line_feeder_skid_fifo.sv
// Two-entry FIFO holding read data together with its sideband tags.
module feeder_skid_fifo
   import interp_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  feeder_beat_t push_beat,
   input  logic         pop,
   output feeder_beat_t head,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   feeder_beat_t entry [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign head    = entry[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         entry[0] <= '0;
         entry[1] <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
      end else begin
         if (do_push) begin
            entry[wr_ptr] <= push_beat;
            wr_ptr        <= !wr_ptr;
         end
         if (do_pop) rd_ptr <= !rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/interp_line_feeder.sv
// Streams a 16x16 block as edge-padded 29-beat lines for the 8-tap interpolator.
// Define FEEDER_COLUMN_MODE_EN to enable column-order (transposed) streaming.
module interp_line_feeder
   import interp_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              col_mode,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  pixel_t            mem_rd_data,
   interp_line_feeder_if.master stream
);

   feeder_state_e state;
   idx_t          line_cnt;
   beat_idx_t     beat_cnt;
   idx_t          col;
   logic          rd_pending;
   idx_t          pend_line;
   beat_idx_t     pend_beat;
   feeder_tags_t  pend_tags;
   feeder_beat_t  push_beat;
   feeder_beat_t  head;
   logic          pop;
   logic          empty;
   logic          unused_full;
   logic [1:0]    count;
   logic [2:0]    occupancy;

   // A pop this cycle frees a slot, so the next read may issue without a bubble.
   assign pop       = !empty && stream.out_ready;
   assign occupancy = {1'b0, count} - {2'b0, pop} + {2'b0, rd_pending};
   assign mem_rd_en = (state == STREAM) && (occupancy < 3'd2);
   assign col       = pad_col(beat_cnt);

`ifdef FEEDER_COLUMN_MODE_EN
   logic col_q;
   assign mem_addr = col_q ? {col, line_cnt} : {line_cnt, col};
`else
   logic unused_col_mode;
   assign unused_col_mode = col_mode;
   assign mem_addr        = {line_cnt, col};
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         line_cnt <= '0;
         beat_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef FEEDER_COLUMN_MODE_EN
         col_q    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state    <= STREAM;
               busy     <= 1'b1;
               line_cnt <= '0;
               beat_cnt <= '0;
`ifdef FEEDER_COLUMN_MODE_EN
               col_q    <= col_mode;
`endif
            end
            STREAM: if (mem_rd_en) begin
               if (beat_cnt == LAST_BEAT) begin
                  beat_cnt <= '0;
                  if (line_cnt == LAST_LINE) begin
                     line_cnt <= '0;
                     state    <= DRAIN;
                  end else begin
                     line_cnt <= line_cnt + idx_t'(1);
                  end
               end else begin
                  beat_cnt <= beat_cnt + beat_idx_t'(1);
               end
            end
            DRAIN: if (pop && head.tags.last) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Tags are fixed at issue time and ride alongside the read until the data lands.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_pending <= 1'b0;
         pend_line  <= '0;
         pend_beat  <= '0;
         pend_tags  <= '0;
      end else begin
         rd_pending <= mem_rd_en;
         if (mem_rd_en) begin
            pend_line <= line_cnt;
            pend_beat <= beat_cnt;
            pend_tags <= make_tags(line_cnt, beat_cnt);
         end
      end
   end

   assign push_beat = '{data: mem_rd_data, line: pend_line, beat: pend_beat, tags: pend_tags};

   feeder_skid_fifo fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rd_pending),
      .push_beat (push_beat),
      .pop       (pop),
      .head      (head),
      .full      (unused_full),
      .empty     (empty),
      .count     (count)
   );

   assign stream.out_valid     = !empty;
   assign stream.out_data      = empty ? '0 : head.data;
   assign stream.out_line      = empty ? '0 : head.line;
   assign stream.out_beat      = empty ? '0 : head.beat;
   assign stream.out_last      = !empty && head.tags.last;
   assign stream.out_tap_valid = !empty && head.tags.tap_valid;
   assign stream.out_tap_idx   = empty ? '0 : head.tags.tap_idx;

endmodule

// File: tb/tb_interp_line_feeder.sv
// Directed bench for interp_line_feeder: row/column streams, backpressure, restart and abort.
module tb_interp_line_feeder;
   import interp_pkg::*;

   localparam int BLOCK_BEATS = 464;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic              col_mode;
   logic              busy;
   logic              done;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   pixel_t            mem_rd_data;

   interp_line_feeder_if stream_if ();

   interp_line_feeder dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .col_mode    (col_mode),
      .busy        (busy),
      .done        (done),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .stream      (stream_if)
   );

   always #5 clock = ~clock;

   pixel_t memory [256];

   always @(posedge clock) begin
      if (mem_rd_en) mem_rd_data <= memory[mem_addr];
   end

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] gotPack [BLOCK_BEATS];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] packBeat(int d, int line, int beat, int last, int tv, int ti);
      logic [31:0] r;
      r = (d << 15) | (line << 11) | (beat << 6) | (last << 5) | (tv << 4) | ti;
      return r;
   endfunction

   function automatic logic [31:0] modelBeat(bit colm, int line, int beat);
      int  c;
      int  d;
      int  tv;
      bit  useCol;
      c = (beat < 7) ? 0 : ((beat > 22) ? 15 : beat - 7);
`ifdef FEEDER_COLUMN_MODE_EN
      useCol = colm;
`else
      useCol = 1'b0;
`endif
      d  = useCol ? (c * 16 + line) : (line * 16 + c);
      tv = (beat >= 13) ? 1 : 0;
      return packBeat(d, line, beat, (line == 15 && beat == 28) ? 1 : 0, tv, tv ? beat - 13 : 0);
   endfunction

   function automatic logic [31:0] observedBeat();
      return packBeat(int'(stream_if.out_data), int'(stream_if.out_line), int'(stream_if.out_beat),
                      int'(stream_if.out_last), int'(stream_if.out_tap_valid), int'(stream_if.out_tap_idx));
   endfunction

   // Runs one block; abortAt >= 0 asserts reset while that beat is at the output.
   task automatic applyStimulus(input bit colm, input bit randomReady, input bit restartMid, input int abortAt);
      int          issued    = 0;
      int          popped    = 0;
      int          beatsSeen = 0;
      int          doneCount = 0;
      int          doneCycle = -1;
      int          maxOut    = 0;
      bit          prevStall = 1'b0;
      bit          rdy;
      logic [31:0] prevPack  = '0;
      logic [31:0] cur;
      for (int i = 0; i < BLOCK_BEATS; i++) gotPack[i] = 'x;
      @(negedge clock);
      start    = 1'b1;
      col_mode = colm;
      stream_if.out_ready = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clock);
         start = restartMid && (cyc == 20);
         if (start) col_mode = ~colm;
         if (cyc == 0) checkOutput("busy_after_start", 32'(busy), 32'd1);
         rdy = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         stream_if.out_ready = rdy;
         #1;
         cur = observedBeat();
         if (prevStall)
            checkOutput("stall_hold", {stream_if.out_valid, cur[30:0]}, {1'b1, prevPack[30:0]});
         if (done) begin
            doneCount++;
            if (doneCycle < 0) doneCycle = cyc;
         end
         if (mem_rd_en) issued++;
         if (abortAt >= 0 && stream_if.out_valid && beatsSeen == abortAt) begin
            checkOutput("abort_beat", cur, modelBeat(colm, abortAt / 29, abortAt % 29));
            #1 reset = 1'b1;
            #1;
            checkOutput("abort_ctrl_zero", 32'({busy, done, mem_rd_en, mem_addr}), 32'd0);
            checkOutput("abort_stream_zero", {stream_if.out_valid, observedBeat()[30:0]}, 32'd0);
            @(negedge clock);
            reset = 1'b0;
            start = 1'b0;
            return;
         end
         if (stream_if.out_valid && rdy) begin
            if (beatsSeen < BLOCK_BEATS) gotPack[beatsSeen] = cur;
            beatsSeen++;
            popped++;
         end
         if (issued - popped > maxOut) maxOut = issued - popped;
         prevStall = stream_if.out_valid && !rdy;
         prevPack  = cur;
         if (doneCycle >= 0 && cyc >= doneCycle + 3) break;
      end
      start = 1'b0;
      checkOutput("done_seen", 32'(doneCycle >= 0), 32'd1);
      checkOutput("done_pulses", 32'(doneCount), 32'd1);
      checkOutput("beat_total", 32'(beatsSeen), 32'(BLOCK_BEATS));
      checkOutput("outstanding_le_2", 32'(maxOut <= 2), 32'd1);
      checkOutput("busy_after_done", 32'(busy), 32'd0);
      for (int i = 0; i < BLOCK_BEATS; i++)
         checkOutput($sformatf("beat_%0d", i), gotPack[i], modelBeat(colm, i / 29, i % 29));
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      col_mode = 1'b0;
      stream_if.out_ready = 1'b0;
      for (int i = 0; i < 256; i++) memory[i] = pixel_t'(i);
      repeat (2) @(negedge clock);
      checkOutput("reset_ctrl", 32'({busy, done, mem_rd_en, mem_addr}), 32'd0);
      checkOutput("reset_stream", {stream_if.out_valid, observedBeat()[30:0]}, 32'd0);
      reset = 1'b0;

      $display("[TB] row order, ready held high");
      applyStimulus(1'b0, 1'b0, 1'b0, -1);
      checkOutput("t1_l0_b0",   gotPack[0],   packBeat(0, 0, 0, 0, 0, 0));
      checkOutput("t1_l0_b6",   gotPack[6],   packBeat(0, 0, 6, 0, 0, 0));
      checkOutput("t1_l0_b7",   gotPack[7],   packBeat(0, 0, 7, 0, 0, 0));
      checkOutput("t1_l0_b13",  gotPack[13],  packBeat(6, 0, 13, 0, 1, 0));
      checkOutput("t1_l0_b22",  gotPack[22],  packBeat(15, 0, 22, 0, 1, 9));
      checkOutput("t1_l0_b28",  gotPack[28],  packBeat(15, 0, 28, 0, 1, 15));
      checkOutput("t1_l3_b7",   gotPack[94],  packBeat(48, 3, 7, 0, 0, 0));
      checkOutput("t1_l3_b22",  gotPack[109], packBeat(63, 3, 22, 0, 1, 9));
      checkOutput("t1_l15_b27", gotPack[462], packBeat(255, 15, 27, 0, 1, 14));
      checkOutput("t1_l15_b28", gotPack[463], packBeat(255, 15, 28, 1, 1, 15));

      $display("[TB] column-mode request");
      applyStimulus(1'b1, 1'b0, 1'b0, -1);
`ifdef FEEDER_COLUMN_MODE_EN
      checkOutput("t2_l2_b0",  gotPack[58], packBeat(2, 2, 0, 0, 0, 0));
      checkOutput("t2_l2_b7",  gotPack[65], packBeat(2, 2, 7, 0, 0, 0));
      checkOutput("t2_l2_b8",  gotPack[66], packBeat(18, 2, 8, 0, 0, 0));
      checkOutput("t2_l2_b22", gotPack[80], packBeat(242, 2, 22, 0, 1, 9));
      checkOutput("t2_l2_b28", gotPack[86], packBeat(242, 2, 28, 0, 1, 15));
`else
      checkOutput("t2_l2_b0",  gotPack[58], packBeat(32, 2, 0, 0, 0, 0));
      checkOutput("t2_l2_b7",  gotPack[65], packBeat(32, 2, 7, 0, 0, 0));
      checkOutput("t2_l2_b8",  gotPack[66], packBeat(33, 2, 8, 0, 0, 0));
      checkOutput("t2_l2_b22", gotPack[80], packBeat(47, 2, 22, 0, 1, 9));
      checkOutput("t2_l2_b28", gotPack[86], packBeat(47, 2, 28, 0, 1, 15));
`endif

      $display("[TB] random backpressure");
      applyStimulus(1'b0, 1'b1, 1'b0, -1);

      $display("[TB] start pulsed while streaming");
      applyStimulus(1'b0, 1'b0, 1'b1, -1);

      $display("[TB] reset at line 5 beat 10, then restart");
      applyStimulus(1'b0, 1'b0, 1'b0, 5 * 29 + 10);
      checkOutput("post_abort_ctrl", 32'({busy, done, mem_rd_en, mem_addr}), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, -1);
      checkOutput("restart_l0_b0", gotPack[0], packBeat(0, 0, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
